// File: rtl/read_queue.sv
// read_queue: in-order word buffer with a strobe-only write side and a
// valid/ready read side. Writes that land on a full queue are dropped and
// latch a sticky overflow flag.
// Optional feature: define READ_QUEUE_BYPASS_EN to let a word written into an
// empty queue appear on the read port in the same cycle.
module read_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic [DATA_WIDTH-1:0]      i_write_data,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic                       o_read_valid,
  input  logic                       i_read_ready,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          overflow_q, overflow_d;

  logic                  isEmpty;
  logic                  isFull;
  logic                  pushAccepted;
  logic                  pushDropped;
  logic                  storeWord;
  logic                  popStored;
  logic                  readValid;
  logic [DATA_WIDTH-1:0] headData;

  // Occupancy flags come only from the registered pointers; the wrap bit
  // tells a full queue apart from an empty one when the addresses match.
  always_comb begin
    isEmpty = (wrPtr_q == rdPtr_q);
    isFull  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  end

`ifdef READ_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming word straight to the read port; if
  // the consumer takes it right away it never touches the storage array.
  always_comb begin
    readValid    = !isEmpty || write_en;
    headData     = isEmpty ? i_write_data : mem[rdPtr_q[AW-1:0]];
    pushAccepted = write_en && !isFull;
    pushDropped  = write_en && isFull;
    popStored    = !isEmpty && i_read_ready;
    storeWord    = pushAccepted && !(isEmpty && i_read_ready);
  end
`else
  // Read side only ever sees stored words, so there is no path from the
  // write inputs to the read outputs and the minimum latency is one cycle.
  always_comb begin
    readValid    = !isEmpty;
    headData     = mem[rdPtr_q[AW-1:0]];
    pushAccepted = write_en && !isFull;
    pushDropped  = write_en && isFull;
    popStored    = !isEmpty && i_read_ready;
    storeWord    = pushAccepted;
  end
`endif

  // Next-state for the pointers and the sticky overflow flag; fullness is
  // judged before any pop in the same cycle, so a write to a full queue is
  // dropped even while a word leaves.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    if (storeWord) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popStored) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (pushDropped) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and flag registers; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are never cleared because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && storeWord) begin
      mem[wrPtr_q[AW-1:0]] <= i_write_data;
    end
  end

  // Output drive; data is held at zero whenever nothing is offered.
  always_comb begin
    o_full       = isFull;
    o_overflow   = overflow_q;
    o_read_valid = readValid;
    o_read_data  = readValid ? headData : '0;
    o_count      = wrPtr_q - rdPtr_q;
  end

endmodule

// File: tb/tb_read_queue.sv
// tb_read_queue: randomized and directed stimulus for read_queue with a
// queue-based reference model and a scoreboard monitor on the read port.
module tb_read_queue;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH) + 1;
`ifdef READ_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] i_write_data;
  logic                  o_full;
  logic                  o_overflow;
  logic                  o_read_valid;
  logic                  i_read_ready;
  logic [DATA_WIDTH-1:0] o_read_data;
  logic [CW-1:0]         o_count;

  int checkCount = 0;
  int errorCount = 0;

  logic [DATA_WIDTH-1:0] expQ [$];
  int                    refCount = 0;
  logic                  refOvf   = 1'b0;
  logic                  expValid;
  logic [DATA_WIDTH-1:0] expData;

  read_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .i_write_data (i_write_data),
    .o_full       (o_full),
    .o_overflow   (o_overflow),
    .o_read_valid (o_read_valid),
    .i_read_ready (i_read_ready),
    .o_read_data  (o_read_data),
    .o_count      (o_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Compare one value and log any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and record which
  // words the queue is expected to hand back later.
  task automatic applyStimulus(input logic we, input logic [DATA_WIDTH-1:0] data,
                               input logic rdy, input logic r);
    @(posedge clk);
    #1;
    write_en     = we;
    i_write_data = data;
    i_read_ready = rdy;
    rst          = r;
    if (r) begin
      expQ.delete();
    end else if (we && refCount < DEPTH) begin
      expQ.push_back(data);
    end
  endtask

  // Reference occupancy and overflow: accepted writes minus reads, with
  // fullness judged before the read of the same cycle.
  always @(posedge clk) begin
    if (rst) begin
      refCount <= 0;
      refOvf   <= 1'b0;
    end else begin
      refCount <= refCount
                + ((write_en && refCount < DEPTH) ? 1 : 0)
                - ((i_read_ready && (refCount > 0 || (BYP && write_en))) ? 1 : 0);
      if (write_en && refCount == DEPTH) begin
        refOvf <= 1'b1;
      end
    end
  end

  // Monitor: mid-cycle, compare status outputs with the model and pop the
  // scoreboard whenever the read port completes a transfer.
  always @(negedge clk) begin
    expValid = (refCount > 0) || (BYP && write_en === 1'b1);
    checkOutput("count", 64'(o_count), 64'(refCount));
    checkOutput("full", 64'(o_full), 64'(refCount == DEPTH));
    checkOutput("overflow", 64'(o_overflow), 64'(refOvf));
    checkOutput("valid", 64'(o_read_valid), 64'(expValid));
    if (!expValid) begin
      checkOutput("data_idle", 64'(o_read_data), 64'(0));
    end else if (rst !== 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboard_nonempty", 64'(0), 64'(1));
      end else if (i_read_ready) begin
        expData = expQ.pop_front();
        checkOutput("data_pop", 64'(o_read_data), 64'(expData));
      end else begin
        checkOutput("data_head", 64'(o_read_data), 64'(expQ[0]));
      end
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    rst          = 1'b1;
    write_en     = 1'b0;
    i_write_data = '0;
    i_read_ready = 1'b0;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] reset state observed");

    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC3, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3F, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), $urandom,
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("drained_scoreboard", 64'(expQ.size()), 64'(0));
    checkOutput("drained_valid", 64'(o_read_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
